pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - segmented carry-lookahead adder/subtractor, one pipeline stage per segment
module pipelined_cla_adder #(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG_W;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~B : B;
    assign c0       = sub | cin;

    // Returns {PX, GX, sum}; every bit carry is formed from the group prefix and ci.
    function automatic logic [SEG_W+1:0] cla_seg(input logic [SEG_W-1:0] a,
                                                 input logic [SEG_W-1:0] b,
                                                 input logic             ci);
        logic [SEG_W-1:0] g, p, s;
        logic             gg, pp;
        g  = a & b;
        p  = a ^ b;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < SEG_W; i++) begin
            s[i] = p[i] ^ (gg | (pp & ci));
            gg   = g[i] | (p[i] & gg);
            pp   = p[i] & pp;
        end
        return {pp, gg, s};
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : stg
        // Operand bits not yet consumed: segments k..NSEG-1.
        localparam int RW = WIDTH - k * SEG_W;

        logic [RW-1:0]          a_cur, b_cur;
        logic                   c_cur, v_cur;
        logic [SEG_W+1:0]       seg_d;
        logic [(k+1)*SEG_W-1:0] sum_d, sum_q;
        logic                   vld_q, gx_q, px_q, ci_q;

        if (k == 0) begin : g_src
            assign a_cur = A;
            assign b_cur = b_eff;
            assign c_cur = c0;
            assign v_cur = in_valid;
            assign sum_d = seg_d[SEG_W-1:0];
        end else begin : g_src
            assign a_cur = stg[k-1].g_fwd.a_q;
            assign b_cur = stg[k-1].g_fwd.b_q;
            assign c_cur = stg[k-1].gx_q | (stg[k-1].px_q & stg[k-1].ci_q);
            assign v_cur = stg[k-1].vld_q;
            assign sum_d = {seg_d[SEG_W-1:0], stg[k-1].sum_q};
        end

        assign seg_d = cla_seg(a_cur[SEG_W-1:0], b_cur[SEG_W-1:0], c_cur);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                sum_q <= '0;
                gx_q  <= 1'b0;
                px_q  <= 1'b0;
                ci_q  <= 1'b0;
            end else if (advance) begin
                vld_q <= v_cur;
                sum_q <= sum_d;
                gx_q  <= seg_d[SEG_W];
                px_q  <= seg_d[SEG_W+1];
                ci_q  <= c_cur;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [RW-SEG_W-1:0] a_q, b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_cur[RW-1:SEG_W];
                    b_q <= b_cur[RW-1:SEG_W];
                end
            end
        end else begin : g_last
            // Carry into the MSB recovered as sum ^ a ^ b at that bit.
            logic msb_c_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    msb_c_q <= 1'b0;
                end else if (advance) begin
                    msb_c_q <= seg_d[SEG_W-1] ^ a_cur[SEG_W-1] ^ b_cur[SEG_W-1];
                end
            end
        end
    end

    assign out_valid = stg[NSEG-1].vld_q;
    assign S         = stg[NSEG-1].sum_q;
    assign cout      = stg[NSEG-1].gx_q | (stg[NSEG-1].px_q & stg[NSEG-1].ci_q);
    assign ovf       = stg[NSEG-1].g_last.msb_c_q ^ cout;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed and randomized self-checking bench for pipelined_cla_adder
module tb_pipelined_cla_adder;
    localparam int W    = 64;
    localparam int NSEG = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] A, B, S;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .SEG_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout), .ovf(ovf)
    );

    // Signed/unsigned arithmetic view: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        logic signed [W+1:0] sa, sb, sr;
        logic [W:0]          ur;
        logic                co, ov;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (s) begin
            sr = sa - sb;
            ur = {1'b0, a} - {1'b0, b};
            co = (a >= b);
        end else begin
            sr = sa + sb + {{(W+1){1'b0}}, c};
            ur = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            co = ur[W];
        end
        ov = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
        return {ov, co, ur[W-1:0]};
    endfunction

    task automatic check64(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s, input logic [W+1:0] e);
        int lat;
        A = a; B = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check1({tag, " in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        check64({tag, " latency"}, 64'(lat), 64'(NSEG));
        check64({tag, " S"}, S, e[W-1:0]);
        check1({tag, " cout"}, cout, e[W]);
        check1({tag, " ovf"}, ovf, e[W+1]);
        step();
    endtask

    initial begin : monitor
        logic         hold;
        logic [W+1:0] held, e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check1("stall out_valid", out_valid, 1'b1);
                    check64("stall S", S, held[W-1:0]);
                    check1("stall cout", cout, held[W]);
                    check1("stall ovf", ovf, held[W+1]);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check1("spurious result", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        n_out++;
                        check64("stream S", S, e[W-1:0]);
                        check1("stream cout", cout, e[W]);
                        check1("stream ovf", ovf, e[W+1]);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(ref_model(A, B, cin, sub));
                hold = out_valid && !out_ready;
                held = {ovf, cout, S};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int           n, base;
        logic [W-1:0] va[8], vb[8];
        logic         vc[8], vs[8];
        logic [W-1:0] s0;
        logic         ra;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'(($urandom & 1));
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; cin = 1'b1; sub = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check1("reset out_valid", out_valid, 1'b0);
            check64("reset S", S, '0);
            check1("reset cout", cout, 1'b0);
            check1("reset ovf", ovf, 1'b0);
            A = {$urandom, $urandom}; B = {$urandom, $urandom};
            cin = 1'(($urandom & 1)); sub = 1'(($urandom & 1));
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check1("in_ready after reset", in_ready, 1'b1);
        step();

        run_one("carry chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                {1'b0, 1'b1, 64'h0});
        run_one("sub 5-7", 64'd5, 64'd7, 1'b0, 1'b1,
                {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_one("sub 7-5", 64'd7, 64'd5, 1'b1, 1'b1,
                {1'b0, 1'b1, 64'd2});
        run_one("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                {1'b1, 1'b0, 64'h8000_0000_0000_0000});

        for (int i = 0; i < 8; i++) begin
            va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
            vc[i] = 1'(($urandom & 1)); vs[i] = 1'(($urandom & 1));
        end
        base = n_out;
        n = 0;
        s0 = '0;
        for (int cyc = 0; cyc < 40 && (n < 8 || exp_q.size() > 0 || out_valid); cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            if (n < 8) begin
                in_valid = 1'b1; A = va[n]; B = vb[n]; cin = vc[n]; sub = vs[n];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                check1("bp in_ready low", in_ready, 1'b0);
                if (cyc == 5) s0 = S;
                else check64("bp S held", S, s0);
            end
            if (in_valid && in_ready) n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check64("bp results", 64'(n_out - base), 64'd8);

        for (int i = 0; i < 3; i++) begin
            A = {$urandom, $urandom}; B = {$urandom, $urandom};
            cin = 1'(($urandom & 1)); sub = 1'(($urandom & 1)); in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check1("flushed out_valid", out_valid, 1'b0);
            step();
        end
        A = {$urandom, $urandom}; B = {$urandom, $urandom};
        run_one("after flush", A, B, 1'b1, 1'b0, ref_model(A, B, 1'b1, 1'b0));

        base = n_out;
        n = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            ra = 1'(($urandom % 4 != 0));
            in_valid = ra;
            out_ready = 1'(($urandom % 3 != 0));
            A = {$urandom, $urandom}; B = ($urandom % 5 == 0) ? ~A : {$urandom, $urandom};
            cin = 1'(($urandom & 1)); sub = 1'(($urandom & 1));
            #1;
            if (in_valid && in_ready) n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        check64("random drain", 64'(n_out - base), 64'(n));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
